// File: rtl/spi_reg_ctrl.sv
// SPI mode-0 target that writes five 8-bit PWM configuration registers from 16-bit frames.
// Optional readback of the registers on cipo is enabled by defining SPI_READBACK_EN.
//
// state  | meaning
// IDLE   | waiting for ncs to fall; sclk activity ignored
// SHIFT  | frame in progress, sampling copi on sclk rising edges
// COMMIT | one clk to validate the frame and update the addressed register
module spi_reg_ctrl #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] MAX_ADDR    = 7'h04
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_pulse,
  output logic       frame_err,
  output logic       cipo
);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, ncs_sync;
  logic                   sclk_d, ncs_d;
  logic                   sclk_s, copi_s, ncs_s;
  logic                   sclk_rise, ncs_rise, ncs_fall;
  logic [15:0]            shift_reg;
  logic [4:0]             bit_cnt;
  logic [6:0]             frame_addr;

  // ncs chain resets high so a low ncs at reset release looks like a frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '1;
      sclk_d    <= 1'b0;
      ncs_d     <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      ncs_d     <= ncs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s     = sclk_sync[SYNC_STAGES-1];
  assign copi_s     = copi_sync[SYNC_STAGES-1];
  assign ncs_s      = ncs_sync[SYNC_STAGES-1];
  assign sclk_rise  = sclk_s & ~sclk_d;
  assign ncs_rise   = ncs_s & ~ncs_d;
  assign ncs_fall   = ~ncs_s & ncs_d;
  assign frame_addr = shift_reg[14:8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      shift_reg       <= '0;
      bit_cnt         <= '0;
      en_reg_out_7_0  <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0  <= '0;
      en_reg_pwm_15_8 <= '0;
      pwm_duty_cycle  <= '0;
      wr_pulse        <= 1'b0;
      frame_err       <= 1'b0;
    end else begin
      wr_pulse  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (ncs_fall) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (ncs_rise) begin
            state <= COMMIT;
          end else if (sclk_rise) begin
            // 17 marks an over-long frame; the first 16 bits are kept
            if (bit_cnt < 5'd16) begin
              shift_reg <= {shift_reg[14:0], copi_s};
              bit_cnt   <= bit_cnt + 5'd1;
            end else begin
              bit_cnt <= 5'd17;
            end
          end
        end
        COMMIT: begin
          if (bit_cnt != 5'd16) begin
            frame_err <= 1'b1;
          end else if (shift_reg[15] && frame_addr <= MAX_ADDR) begin
            wr_pulse <= 1'b1;
            case (frame_addr)
              7'h00:   en_reg_out_7_0  <= shift_reg[7:0];
              7'h01:   en_reg_out_15_8 <= shift_reg[7:0];
              7'h02:   en_reg_pwm_7_0  <= shift_reg[7:0];
              7'h03:   en_reg_pwm_15_8 <= shift_reg[7:0];
              7'h04:   pwm_duty_cycle  <= shift_reg[7:0];
              default: ;
            endcase
          end
          if (ncs_fall) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            state     <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_READBACK_EN
  logic       sclk_fall;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] tx_reg;

  assign sclk_fall = ~sclk_s & sclk_d;
  // address as it will stand once the 8th bit is shifted in
  assign rd_addr   = {shift_reg[5:0], copi_s};

  always_comb begin
    rd_data = 8'h00;
    if (rd_addr <= MAX_ADDR) begin
      case (rd_addr)
        7'h00:   rd_data = en_reg_out_7_0;
        7'h01:   rd_data = en_reg_out_15_8;
        7'h02:   rd_data = en_reg_pwm_7_0;
        7'h03:   rd_data = en_reg_pwm_15_8;
        7'h04:   rd_data = pwm_duty_cycle;
        default: rd_data = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_reg <= '0;
      cipo   <= 1'b0;
    end else if (ncs_s || ncs_fall) begin
      tx_reg <= '0;
      cipo   <= 1'b0;
    end else if (state == SHIFT) begin
      if (sclk_rise && bit_cnt == 5'd7 && !shift_reg[6]) begin
        tx_reg <= rd_data;
      end else if (sclk_fall) begin
        cipo   <= tx_reg[7];
        tx_reg <= {tx_reg[6:0], 1'b0};
      end
    end
  end
`else
  assign cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: SCLK = clk/10, frames driven from negedge clk.
// Readback is exercised only when SPI_READBACK_EN is defined.
module tb_spi_reg_ctrl;

  localparam int SYNC_STAGES = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       copi = 1'b0;
  logic       ncs = 1'b1;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic       wr_pulse, frame_err, cipo;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int err_cnt = 0;
  int wr_base, err_base;
  logic [7:0] rd_byte;

  spi_reg_ctrl #(.SYNC_STAGES(SYNC_STAGES), .MAX_ADDR(7'h04)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .wr_pulse(wr_pulse), .frame_err(frame_err),
    .cipo(cipo)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && wr_pulse)  wr_cnt  = wr_cnt + 1;
    if (rst_n && frame_err) err_cnt = err_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic half_sclk();
    repeat (5) @(negedge clk);
  endtask

  // Drives nbits of bits MSB first; captures cipo before the rising edges of the last 8 bits.
  task automatic spi_frame(input logic [31:0] bits, input int nbits, output logic [7:0] rd);
    rd = 8'h00;
    @(negedge clk);
    ncs = 1'b0;
    for (int j = nbits - 1; j >= 0; j--) begin
      copi = bits[j];
      half_sclk();
      if (j < 8) rd = {rd[6:0], cipo};
      sclk = 1'b1;
      half_sclk();
      sclk = 1'b0;
    end
    half_sclk();
    ncs = 1'b1;
  endtask

  task automatic wait_commit();
    repeat (SYNC_STAGES + 2) @(posedge clk);
    #1;
  endtask

  task automatic chk_regs(input string tag, input logic [39:0] exp);
    chk(tag, {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle}, exp);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_regs("reset_regs", 40'h0);
    chk("reset_pulses", {wr_pulse, frame_err, cipo}, 3'b000);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    wr_base = wr_cnt;
    spi_frame(32'h80F0, 16, rd_byte);
    wait_commit();
    chk("wr0_latency", en_reg_out_7_0, 8'hF0);
    chk("wr0_pulse_now", wr_pulse, 1'b1);
    repeat (10) @(negedge clk);
    chk_regs("wr0_regs", 40'hF0_00_00_00_00);
    chk("wr0_pulses", wr_cnt - wr_base, 1);

    spi_frame(32'h8480, 16, rd_byte);
    repeat (10) @(negedge clk);
    chk_regs("duty_regs", 40'hF0_00_00_00_80);
    wr_base = wr_cnt; err_base = err_cnt;
    spi_frame(32'h8705, 16, rd_byte);
    repeat (10) @(negedge clk);
    chk_regs("bad_addr_regs", 40'hF0_00_00_00_80);
    chk("bad_addr_wr", wr_cnt - wr_base, 0);
    chk("bad_addr_err", err_cnt - err_base, 0);

    wr_base = wr_cnt; err_base = err_cnt;
    spi_frame(32'h8AB, 12, rd_byte);
    repeat (10) @(negedge clk);
    spi_frame(32'h20155, 18, rd_byte);
    repeat (10) @(negedge clk);
    chk_regs("len_regs", 40'hF0_00_00_00_80);
    chk("len_err", err_cnt - err_base, 2);
    chk("len_wr", wr_cnt - wr_base, 0);

    // ncs high for one SCLK period between frames
    wr_base = wr_cnt;
    spi_frame(32'h8155, 16, rd_byte);
    repeat (9) @(negedge clk);
    spi_frame(32'h82AA, 16, rd_byte);
    repeat (10) @(negedge clk);
    chk_regs("b2b_regs", 40'hF0_55_AA_00_80);
    chk("b2b_wr", wr_cnt - wr_base, 2);

`ifdef SPI_READBACK_EN
    spi_frame(32'h833C, 16, rd_byte);
    repeat (10) @(negedge clk);
    chk("rb_write", en_reg_pwm_15_8, 8'h3C);
    wr_base = wr_cnt; err_base = err_cnt;
    spi_frame(32'h0300, 16, rd_byte);
    repeat (10) @(negedge clk);
    chk("rb_data", rd_byte, 8'h3C);
    chk("rb_no_wr", wr_cnt - wr_base, 0);
    chk("rb_no_err", err_cnt - err_base, 0);
    chk("rb_cipo_idle", cipo, 1'b0);
`else
    wr_base = wr_cnt; err_base = err_cnt;
    spi_frame(32'h0355, 16, rd_byte);
    repeat (10) @(negedge clk);
    chk("read_dropped_regs", en_reg_pwm_15_8, 8'h00);
    chk("read_dropped_pulses", (wr_cnt - wr_base) + (err_cnt - err_base), 0);
    chk("cipo_tied", rd_byte, 8'h00);
`endif

    // reset mid-frame with ncs held low across release
    @(negedge clk);
    ncs = 1'b0;
    for (int k = 0; k < 5; k++) begin
      copi = 1'b1;
      half_sclk();
      sclk = 1'b1;
      half_sclk();
      sclk = 1'b0;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_regs("midrst_regs", 40'h0);
    chk("midrst_pulses", {wr_pulse, frame_err, cipo}, 3'b000);
    rst_n = 1'b1;
    wr_base = wr_cnt; err_base = err_cnt;
    for (int k = 0; k < 4; k++) begin
      copi = 1'b1;
      half_sclk();
      sclk = 1'b1;
      half_sclk();
      sclk = 1'b0;
    end
    half_sclk();
    ncs = 1'b1;
    repeat (10) @(negedge clk);
    chk("midrst_err", err_cnt - err_base, 1);
    chk("midrst_wr", wr_cnt - wr_base, 0);
    chk_regs("midrst_after", 40'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
- SPI target (mode 0) that configures the PWM peripheral.
- Receives 16-bit write frames on externally driven SCLK/COPI/nCS pins.
- Synchronizes those pins into the system clock domain, then updates five 8-bit config registers: output enables, PWM enables, PWM duty cycle.
- Sits between the ui_in pins and the PWM peripheral in the top level.

Parameters:
- SYNC_STAGES, 2, number of flops in each input synchronizer chain (min 2).
- MAX_ADDR, 7'h04, highest writable register address; writes above it are dropped.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- sclk  input  1  SPI clock (async to clk)
- copi  input  1  SPI data in, MSB first
- ncs  input  1  SPI chip select, active low
- en_reg_out_7_0  output  8  addr 0x00
- en_reg_out_15_8  output  8  addr 0x01
- en_reg_pwm_7_0  output  8  addr 0x02
- en_reg_pwm_15_8  output  8  addr 0x03
- pwm_duty_cycle  output  8  addr 0x04
- wr_pulse  output  1  one-clk pulse when a register is updated
- frame_err  output  1  one-clk pulse when a frame is discarded
- cipo  output  1  SPI data out (only with SPI_READBACK_EN; otherwise tied 0)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active low. All outputs and registers clear to 0 on reset.
- Synchronizer reset values: ncs chain resets to 1; sclk and copi chains reset to 0.
- Synchronization: sclk, copi and ncs each pass through SYNC_STAGES flops. Edge detect compares the last sync stage with one extra delay flop.
- SCLK timing guarantee: SCLK high and low times are each ≥ 4 clk periods. No other CDC handling is required.
- Frame format (16 bits, MSB first):
  - bit15: R/W, 1 = write.
  - bits14:8: address.
  - bits7:0: data.
  - COPI is sampled on the synced SCLK rising edge.
- FSM states: IDLE, SHIFT, COMMIT.
  - IDLE: on synced ncs falling edge, clear the 16-bit shift reg and the 5-bit bit count, then go to SHIFT.
  - SHIFT: each synced sclk rising edge shifts in synced copi and increments the count. The count saturates at 17 (overflow marker); shifting stops after 16 bits. On synced ncs rising edge, go to COMMIT.
  - COMMIT (exactly 1 clk):
    - Frame is valid if count == 16 AND bit15 == 1 AND addr ≤ MAX_ADDR. Then write the data byte to the addressed register and pulse wr_pulse.
    - count ≠ 16 (short or over-long frame): pulse frame_err, no write.
    - Valid length with bit15 == 0, or addr > MAX_ADDR: silently dropped, no pulse.
    - Return to IDLE.
- SCLK edges while in IDLE are ignored.
- Latency: the register value changes on the clk edge ending COMMIT. That is SYNC_STAGES+2 clk after the raw ncs rising edge.
- Simultaneous events: a ncs falling edge detected during COMMIT is honoured. FSM goes COMMIT→SHIFT directly, with shift reg and count cleared.
- Reset mid-frame:
  - Everything clears and the FSM returns to IDLE.
  - If ncs is still low at reset release, the reset value 1 in the ncs sync chain produces a falling edge, so a new frame starts.
  - That partial frame then fails the length check → frame_err.
- Registers hold their values indefinitely between writes. Only COMMIT writes them.

Optional Feature:
- Macro: SPI_READBACK_EN.
- When defined, a frame with bit15 == 0 is a read:
  - After the 8th synced sclk rising edge, the addressed register (0 if addr > MAX_ADDR) loads a TX shift reg.
  - Each synced sclk falling edge shifts it out MSB first on cipo.
  - The read is not counted as a write; no wr_pulse.
  - cipo is 0 while ncs is high.
- When undefined, cipo is tied 0 and read frames are dropped as above.

Test Plan:
- Reset: assert rst_n=0 mid-operation → all five registers = 0x00, wr_pulse = frame_err = 0, cipo = 0.
- Write 0x80F0 (addr 0x00, data 0xF0) with SCLK = clk/10 → en_reg_out_7_0 = 0xF0 and one wr_pulse, within SYNC_STAGES+2 clk of ncs rise. Other registers unchanged.
- Write 0x8480 (duty = 0x80), then write 0x8705 (addr 0x07 > MAX_ADDR) → pwm_duty_cycle = 0x80, no register changes on the second frame, no frame_err.
- Short frame of 12 bits, then frame of 18 bits, each with write bit set → no register change, frame_err pulses twice.
- Back-to-back frames 0x8155 and 0x82AA with ncs high for only 1 SCLK period → en_reg_out_15_8 = 0x55, en_reg_pwm_7_0 = 0xAA, two wr_pulses.
- With SPI_READBACK_EN defined: write 0x833C, then read frame 0x0300 → cipo shifts out 0x3C (00111100) during bits 8–15.
